// File: rtl/scan_pattern_unloader_if.sv
// scan_pattern_unloader_if: sequencer-side and DUT-scan-side signals of the s27 pattern unloader.
interface scan_pattern_unloader_if #(
    parameter int CHAIN_LEN = 3,
    parameter int SIG_W     = 16
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern;
    logic                 sig_clr;
    logic                 SO;
    logic                 PO;
    logic                 SE;
    logic                 SI;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] response;
    logic                 po_cap;
    logic [SIG_W-1:0]     signature;
    modport slave (
        input  start, pattern, sig_clr, SO, PO,
        output SE, SI, busy, done, response, po_cap, signature
    );
    modport master (
        output start, pattern, sig_clr, SO, PO,
        input  SE, SI, busy, done, response, po_cap, signature
    );
endinterface

// File: rtl/scan_pattern_unloader.sv
// scan_pattern_unloader: shifts a pattern into the s27 chain, captures once, unloads and compacts into a MISR.
module scan_pattern_unloader #(
    parameter int                 CHAIN_LEN = 3,
    parameter int                 SIG_W     = 16,
    parameter logic [SIG_W-1:0]   POLY      = 16'h1021
) (
    input  logic                  CK,
    input  logic                  RST,
    scan_pattern_unloader_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam int CW = $clog2(CHAIN_LEN);
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [CHAIN_LEN-1:0] r_pat;
    logic [CHAIN_LEN-1:0] r_resp;
    logic [CHAIN_LEN-1:0] r_response;
    logic                 r_po_cap;
    logic [SIG_W-1:0]     r_sig;
    logic                 w_last;
    logic [SIG_W-1:0]     w_d;
    logic [SIG_W-1:0]     w_next_sig;
    assign w_last     = r_cnt == CW'(CHAIN_LEN - 1);
    assign w_d        = SIG_W'({r_resp, r_po_cap});
    assign w_next_sig = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY : '0) ^ w_d;
    // Outputs decode the registered state only, so SE cannot glitch.
    assign bus.SE        = r_state != S_CAPTURE;
    assign bus.SI        = r_state == S_SHIFT_IN ? r_pat[CHAIN_LEN-1] : 1'b0;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
    assign bus.response  = r_response;
    assign bus.po_cap    = r_po_cap;
    assign bus.signature = r_sig;
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pat      <= '0;
            r_resp     <= '0;
            r_response <= '0;
            r_po_cap   <= 1'b0;
            r_sig      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pat   <= bus.pattern;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT_IN;
                    end else if (bus.sig_clr) begin
                        r_sig <= '0;
                    end
                end
                S_SHIFT_IN: begin
                    r_pat   <= r_pat << 1;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    r_state <= w_last ? S_CAPTURE : S_SHIFT_IN;
                end
                S_CAPTURE: begin
                    r_po_cap <= bus.PO;
                    r_cnt    <= '0;
                    r_state  <= S_SHIFT_OUT;
                end
                S_SHIFT_OUT: begin
                    r_resp  <= {r_resp[CHAIN_LEN-2:0], bus.SO};
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    r_state <= w_last ? S_DONE : S_SHIFT_OUT;
                end
                S_DONE: begin
                    r_response <= r_resp;
                    r_sig      <= w_next_sig;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/scan_pattern_unloader.md
Name: scan_pattern_unloader

Overview:
- Scan-test controller for the s27 scan-chain DUT; the response side of our s27 stimulus benches.
- Per pattern, it:
  - shifts a parallel test pattern into the DUT scan chain;
  - issues a single functional capture cycle and samples the primary output;
  - shifts the captured state back out;
  - compacts the response into a MISR signature.
- Sits between the bench/ATE sequencer and the DUT scan pins (SE, SI, SO, G17).

Parameters:
- CHAIN_LEN, 3, number of scan flops in the DUT chain (>=2).
- SIG_W, 16, MISR signature width (must be >= CHAIN_LEN+1).
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits; bit i set = tap on sig bit i.

Ports:
- CK  input  1  clock; all state on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request one pattern; sampled only in IDLE.
- pattern  input  CHAIN_LEN  scan-in pattern; latched at start acceptance.
- sig_clr  input  1  synchronous clear of the signature; honoured only in IDLE.
- SO  input  1  scan-out of the last chain flop.
- PO  input  1  DUT primary output (G17).
- SE  output  1  scan enable to the DUT (1 = shift, 0 = functional).
- SI  output  1  scan-in to the first chain flop.
- busy  output  1  high from the cycle after acceptance until DONE exits.
- done  output  1  one-cycle pulse; response and signature are valid.
- response  output  CHAIN_LEN  last unloaded chain contents; first bit out lands in the MSB.
- po_cap  output  1  PO sampled at the capture edge.
- signature  output  SIG_W  MISR state.

Behaviour:
- Reset (asynchronous, RST=1): all of the following, regardless of state.
  - State returns to IDLE; the shift counter is cleared.
  - SE=1, SI=0, busy=0, done=0, response=0, po_cap=0, signature=0.
  - A pattern in flight is abandoned.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - SE=1, SI=0.
  - If start=1 at an edge: latch pattern into pat_sr, clear the counter, go to SHIFT_IN.
  - Else, if sig_clr=1: signature <= 0. start has priority over sig_clr in the same cycle; that sig_clr is ignored.
- SHIFT_IN, CHAIN_LEN cycles:
  - SE=1, SI=pat_sr[CHAIN_LEN-1], MSB first.
  - At each edge, pat_sr shifts left and the counter increments.
  - On the last edge, go to CAPTURE.
- CAPTURE, exactly 1 cycle:
  - SE=0, SI=0.
  - At the edge: po_cap <= PO; go to SHIFT_OUT.
- SHIFT_OUT, CHAIN_LEN cycles:
  - SE=1, SI=0; the chain is flushed with zeros.
  - At each edge: resp_sr <= {resp_sr[CHAIN_LEN-2:0], SO}.
  - The first sample is the captured last-flop value present before any shift.
  - On the last edge, go to DONE.
- DONE, exactly 1 cycle:
  - done=1, SE=1.
  - At the edge: response <= resp_sr.
  - MISR update, computed as follows:
    - d = zero-extended {resp_sr, po_cap} into SIG_W bits.
    - signature <= ({signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0)) ^ d.
  - Then go to IDLE.
- busy=1 in SHIFT_IN, CAPTURE, SHIFT_OUT and DONE.
- Timing:
  - start to done pulse is 2*CHAIN_LEN+2 cycles after acceptance.
  - Back-to-back: start may be accepted in the first IDLE cycle after DONE.
- start while busy: ignored; not queued.
- pattern changes after acceptance: no effect on the pattern in flight.
- SE is low only in CAPTURE; no glitches, since SE is registered or decoded from the registered state only.
- response and po_cap hold between patterns; signature accumulates across patterns until sig_clr or RST.

Test Plan:
- Reset, then idle 5 cycles -> SE=1, SI=0, busy=0, done=0, response=0, signature=16'h0000.
- CHAIN_LEN=3, pattern=3'b101, start one cycle; SO driven by a bench 3-flop chain model whose capture holds its state; PO=1 -> SI sequence 1,0,1; SE low exactly cycle 4; done on cycle 8; response=3'b101; po_cap=1; signature=16'h000B.
- Second pattern 3'b011 with PO=0, no sig_clr -> response=3'b011; signature=(16'h000B<<1)^16'h0006=16'h0010.
- start held high through a whole pattern -> only one pattern runs; next acceptance in the IDLE cycle after done; sig_clr and start together in IDLE -> pattern runs, signature not cleared.
- RST asserted mid-SHIFT_OUT (cycle 6) -> same cycle: busy=0, SE=1, response=0, signature=0; next start runs a clean pattern with correct results.
- Model chain with capture = invert, pattern 3'b000 -> response=3'b111; sig_clr in IDLE then zeroes signature on the next edge.
